johnson_readout: RTL

- Reads one 3-digit sample from the capture stage (hundreds, tens and ones digits, each a 5-bit Johnson code) and decodes each digit to BCD.
- Transmits the result as a framed nibble stream on a 4-bit output bus, for the design's unused io_out[3:0] pins.
- Flags any Johnson code outside the 10 legal states.
- Lives entirely in the external i_clk domain. Its inputs are already synchronised by the capture stage.

---
 rtl/johnson_readout_if.sv | 24 ++
 rtl/johnson_readout.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/johnson_readout_if.sv
// Bus bundle for johnson_readout: frame request, three Johnson digits and
// the framed nibble stream returned by the block.
interface johnson_readout_if;
  logic       i_start;
  logic [4:0] i_100;
  logic [4:0] i_010;
  logic [4:0] i_001;
  logic [3:0] o_nibble;
  logic       o_strobe;
  logic       o_busy;
  logic       o_err;

  // Requester side: drives start and digits, observes the stream
  modport master (
    output i_start, i_100, i_010, i_001,
    input  o_nibble, o_strobe, o_busy, o_err
  );

  // Block side
  modport slave (
    input  i_start, i_100, i_010, i_001,
    output o_nibble, o_strobe, o_busy, o_err
  );
endinterface

// File: rtl/johnson_readout.sv
// johnson_readout: latches a 3-digit Johnson-coded sample on request,
// decodes each digit to BCD and sends header, three digits and a status
// nibble, each held for pHOLD clocks, on a 4-bit bus.
module johnson_readout #(
  parameter int unsigned pHOLD   = 4,
  parameter logic [3:0]  pHEADER = 4'hA
) (
  input  logic          i_clk,
  input  logic          i_rst,
  johnson_readout_if.slave bus
);

  localparam int unsigned CNT_W = (pHOLD > 1) ? $clog2(pHOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pHOLD - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    D100 = 3'd2,
    D010 = 3'd3,
    D001 = 3'd4,
    STAT = 3'd5
  } state_t;

  // Johnson code to {error, BCD value}; illegal codes give {1, 4'hF}
  function automatic logic [4:0] jdec(input logic [4:0] code);
    logic [4:0] res;
    case (code)
      5'b00000: res = {1'b0, 4'd0};
      5'b00001: res = {1'b0, 4'd1};
      5'b00011: res = {1'b0, 4'd2};
      5'b00111: res = {1'b0, 4'd3};
      5'b01111: res = {1'b0, 4'd4};
      5'b11111: res = {1'b0, 4'd5};
      5'b11110: res = {1'b0, 4'd6};
      5'b11100: res = {1'b0, 4'd7};
      5'b11000: res = {1'b0, 4'd8};
      5'b10000: res = {1'b0, 4'd9};
      default:  res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [4:0]       dig_100, dig_010, dig_001;
  logic             load;
  logic [3:0]       nib_nx;
  logic             strobe_nx;
  logic             busy_nx;
  logic             last;

  logic [4:0] dec_100, dec_010, dec_001;
  logic       any_err;
  logic [3:0] status;

  // Decode operates only on the latched copy of the sample
  always_comb begin
    dec_100 = jdec(dig_100);
    dec_010 = jdec(dig_010);
    dec_001 = jdec(dig_001);
    any_err = dec_100[4] | dec_010[4] | dec_001[4];
    status  = {any_err, dec_001[4], dec_010[4], dec_100[4]};
  end

  // o_err is a pure function of flops, so it changes only on the
  // accepting edge or reset and has no path from the live inputs
  assign bus.o_err = any_err;

  assign last = (cnt == CNT_LAST);

  // State, hold counter, latched digits and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dig_100      <= '0;
      dig_010      <= '0;
      dig_001      <= '0;
      bus.o_nibble <= '0;
      bus.o_strobe <= 1'b0;
      bus.o_busy   <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      bus.o_nibble <= nib_nx;
      bus.o_strobe <= strobe_nx;
      bus.o_busy   <= busy_nx;
      if (load) begin
        dig_100 <= bus.i_100;
        dig_010 <= bus.i_010;
        dig_001 <= bus.i_001;
      end
    end
  end

  // Next state, counter and next output values
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    load      = 1'b0;
    nib_nx    = bus.o_nibble;
    strobe_nx = 1'b0;
    busy_nx   = bus.o_busy;

    if (state == IDLE) begin
      nib_nx  = 4'h0;
      busy_nx = 1'b0;
      if (bus.i_start) begin
        load      = 1'b1;
        state_nx  = HDR;
        cnt_nx    = '0;
        nib_nx    = pHEADER;
        strobe_nx = 1'b1;
        busy_nx   = 1'b1;
      end
    end else if (!last) begin
      cnt_nx = cnt + CNT_W'(1);
    end else begin
      cnt_nx    = '0;
      strobe_nx = 1'b1;
      case (state)
        HDR: begin
          state_nx = D100;
          nib_nx   = dec_100[3:0];
        end
        D100: begin
          state_nx = D010;
          nib_nx   = dec_010[3:0];
        end
        D010: begin
          state_nx = D001;
          nib_nx   = dec_001[3:0];
        end
        D001: begin
          state_nx = STAT;
          nib_nx   = status;
        end
        default: begin
          // End of STAT, or an unreachable encoding: back to idle
          state_nx  = IDLE;
          nib_nx    = 4'h0;
          strobe_nx = 1'b0;
          busy_nx   = 1'b0;
        end
      endcase
    end
  end

endmodule
